writeback_ctrl: RTL and testbench

- Sequences the writeback stage. Accepts one instruction at a time from the memory stage over a valid/ready handshake and registers its PC, ALU result and destination register.
- Drives the writeback datapath's rd-mux select and issues a single register-file write per retired instruction.
- For loads, stalls until the data-memory response arrives.
- Exposes the pending destination register to the hazard unit.

---
 rtl/rvga_types.sv | 28 ++
 rtl/wb_instret_counter.sv | 25 ++
 rtl/writeback_ctrl.sv | 132 +++++++++++++
 tb/tb_writeback_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_types.sv
// rtl/rvga_types.sv - shared writeback-stage types: word, writeback type, rd-mux select, FSM state
package rvga_types;

    localparam int RVGA_XLEN = 32;

    typedef logic [RVGA_XLEN-1:0] rvga_word;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LINK = 2'd2,
        WB_LOAD = 2'd3
    } wb_type_e;

    typedef enum logic [1:0] {
        RDMUX_ALU  = 2'd0,
        RDMUX_PC4  = 2'd1,
        RDMUX_LD   = 2'd2,
        RDMUX_ZERO = 2'd3
    } rdmux_sel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        WAIT_LD = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_instret_counter.sv
// rtl/wb_instret_counter.sv - 64-bit retired-instruction counter with enable and sync reset
// Only built when RVGA_INSTRET_EN is defined; otherwise no counter flops exist.
`ifdef RVGA_INSTRET_EN
module wb_instret_counter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    // Natural modulo-2^64 wrap from all-ones back to zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count_o = r_count;

endmodule
`endif

// File: rtl/writeback_ctrl.sv
// rtl/writeback_ctrl.sv - writeback-stage sequencer: holds one instruction, drives rd-mux and rf write
// Optional retired-instruction counter enabled by RVGA_INSTRET_EN.
module writeback_ctrl
    import rvga_types::*;
#(
    parameter int xlen_p           = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  wb_type_e                    wb_type_i,
    input  logic [reg_addr_width_p-1:0] rd_addr_i,
    input  logic [xlen_p-1:0]           pc_i,
    input  logic [xlen_p-1:0]           alu_result_i,
    input  logic                        flush_i,
    input  logic                        ld_valid_i,
    input  logic                        ld_err_i,
    output logic [xlen_p-1:0]           pc_o,
    output logic [xlen_p-1:0]           alu_result_o,
    output logic [1:0]                  rdmux_sel_o,
    output logic                        rd_we_o,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    output logic                        busy_o,
    output logic [reg_addr_width_p-1:0] busy_rd_o,
    output logic                        ld_exc_o,
    output logic [63:0]                 instret_o
);

    wb_state_e                   r_state;
    wb_type_e                    r_type;
    logic [reg_addr_width_p-1:0] r_rd;
    logic [xlen_p-1:0]           r_pc;
    logic [xlen_p-1:0]           r_alu;

    wb_state_e w_next_state;
    logic      w_accept;
    logic      w_rd_nz;
    logic      w_retire;

    assign w_rd_nz = (r_rd != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_type  <= WB_NONE;
            r_rd    <= '0;
            r_pc    <= '0;
            r_alu   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_type <= wb_type_i;
                r_rd   <= rd_addr_i;
                r_pc   <= pc_i;
                r_alu  <= alu_result_i;
            end
        end
    end

    // Outputs are also gated by reset_i so a response landing during reset is dropped.
    always_comb begin
        w_next_state = r_state;
        ready_o      = (r_state != WAIT_LD);
        w_accept     = valid_i && ready_o && !flush_i;
        rdmux_sel_o  = RDMUX_ZERO;
        rd_we_o      = 1'b0;
        ld_exc_o     = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            HOLD: begin
                case (r_type)
                    WB_ALU:  rdmux_sel_o = RDMUX_ALU;
                    WB_LINK: rdmux_sel_o = RDMUX_PC4;
                    default: rdmux_sel_o = RDMUX_ZERO;
                endcase
                rd_we_o  = ((r_type == WB_ALU) || (r_type == WB_LINK)) && w_rd_nz && !flush_i;
                w_retire = !flush_i;
            end
            WAIT_LD: begin
                rdmux_sel_o = RDMUX_LD;
                rd_we_o     = ld_valid_i && !ld_err_i && w_rd_nz && !flush_i;
                ld_exc_o    = ld_valid_i && ld_err_i && !flush_i;
                w_retire    = ld_valid_i && !ld_err_i && !flush_i;
            end
            default: ;
        endcase

        case (r_state)
            WAIT_LD: if (ld_valid_i) w_next_state = IDLE;
            default: begin
                if (w_accept) begin
                    w_next_state = (wb_type_i == WB_LOAD) ? WAIT_LD : HOLD;
                end else begin
                    w_next_state = IDLE;
                end
            end
        endcase

        if (flush_i) begin
            w_next_state = IDLE;
        end

        if (reset_i) begin
            rd_we_o  = 1'b0;
            ld_exc_o = 1'b0;
            w_retire = 1'b0;
        end
    end

    assign pc_o         = r_pc;
    assign alu_result_o = r_alu;
    assign rd_addr_o    = r_rd;
    assign busy_o       = (r_state != IDLE);
    assign busy_rd_o    = busy_o ? r_rd : '0;

`ifdef RVGA_INSTRET_EN
    wb_instret_counter u_instret_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_retire),
        .count_o (instret_o)
    );
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign instret_o       = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// tb/tb_writeback_ctrl.sv - directed self-checking bench for writeback_ctrl with write scoreboard
module tb_writeback_ctrl;
    import rvga_types::*;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset_i, valid_i, flush_i, ld_valid_i, ld_err_i;
    wb_type_e    wb_type_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] pc_i, alu_result_i;
    logic        ready_o, rd_we_o, busy_o, ld_exc_o;
    logic [31:0] pc_o, alu_result_o;
    logic [1:0]  rdmux_sel_o;
    logic [4:0]  rd_addr_o, busy_rd_o;
    logic [63:0] instret_o;

    wr_exp_t     sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_instret = 64'd0;

    always #5 clk = ~clk;

    writeback_ctrl #(.xlen_p(32), .reg_addr_width_p(5)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .wb_type_i(wb_type_i), .rd_addr_i(rd_addr_i), .pc_i(pc_i),
        .alu_result_i(alu_result_i), .flush_i(flush_i), .ld_valid_i(ld_valid_i),
        .ld_err_i(ld_err_i), .pc_o(pc_o), .alu_result_o(alu_result_o),
        .rdmux_sel_o(rdmux_sel_o), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
        .busy_o(busy_o), .busy_rd_o(busy_rd_o), .ld_exc_o(ld_exc_o),
        .instret_o(instret_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_instret(input string tag);
`ifdef RVGA_INSTRET_EN
        chk(tag, instret_o, exp_instret);
`else
        chk(tag, instret_o, 64'd0);
`endif
    endtask

    // Drive an instruction and record the write it should eventually produce.
    task automatic present(input wb_type_e t, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] alu);
        wr_exp_t e;
        valid_i = 1'b1; wb_type_i = t; rd_addr_i = rd; pc_i = pc; alu_result_i = alu;
        e.rd   = rd;
        e.sel  = (t == WB_ALU) ? 2'd0 : (t == WB_LINK) ? 2'd1 : 2'd2;
        e.data = (t == WB_ALU) ? alu : pc;
        if (rd != 5'd0 && t != WB_NONE) sb.push_back(e);
    endtask

    // Check this cycle's write against the scoreboard, then advance one clock.
    task automatic step();
        wr_exp_t e;
        #1;
        if (rd_we_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {59'd0, rd_addr_o}, 64'hffff);
            end else begin
                e = sb.pop_front();
                chk("wr_rd", {59'd0, rd_addr_o}, {59'd0, e.rd});
                chk("wr_sel", {62'd0, rdmux_sel_o}, {62'd0, e.sel});
                chk("wr_data", {32'd0, (rdmux_sel_o == 2'd0) ? alu_result_o : pc_o}, {32'd0, e.data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ld_valid_i = 1'b0; ld_err_i = 1'b0;
        wb_type_i = WB_NONE; rd_addr_i = '0; pc_i = '0; alu_result_i = '0;
        @(posedge clk); #1;
        step();
        reset_i = 1'b0;
        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_sel", {62'd0, rdmux_sel_o}, 64'd3);
        chk("rst_we", {63'd0, rd_we_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_busy_rd", {59'd0, busy_rd_o}, 64'd0);
        chk("rst_exc", {63'd0, ld_exc_o}, 64'd0);
        chk("rst_pc", {32'd0, pc_o}, 64'd0);
        chk("rst_alu", {32'd0, alu_result_o}, 64'd0);
        chk_instret("rst_instret");

        // single ALU write
        present(WB_ALU, 5'd5, 32'h40, 32'h1234);
        step();
        valid_i = 1'b0;
        #1;
        chk("alu_we", {63'd0, rd_we_o}, 64'd1);
        chk("alu_rd", {59'd0, rd_addr_o}, 64'd5);
        chk("alu_sel", {62'd0, rdmux_sel_o}, 64'd0);
        chk("alu_res", {32'd0, alu_result_o}, 64'h1234);
        chk("alu_busy_rd", {59'd0, busy_rd_o}, 64'd5);
        step(); exp_instret++;
        chk_instret("alu_instret");

        // LINK then ALU back-to-back
        present(WB_LINK, 5'd1, 32'h100, 32'hdead);
        step();
        present(WB_ALU, 5'd2, 32'h104, 32'h55);
        #1;
        chk("b2b_ready", {63'd0, ready_o}, 64'd1);
        chk("b2b_link_sel", {62'd0, rdmux_sel_o}, 64'd1);
        chk("b2b_link_we", {63'd0, rd_we_o}, 64'd1);
        step(); exp_instret++;
        valid_i = 1'b0;
        #1;
        chk("b2b_alu_sel", {62'd0, rdmux_sel_o}, 64'd0);
        chk("b2b_alu_we", {63'd0, rd_we_o}, 64'd1);
        step(); exp_instret++;
        chk_instret("b2b_instret");

        // load with response three cycles after accept
        present(WB_LOAD, 5'd7, 32'h200, 32'h0);
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ld_wait_ready", {63'd0, ready_o}, 64'd0);
            chk("ld_wait_busy_rd", {59'd0, busy_rd_o}, 64'd7);
            chk("ld_wait_we", {63'd0, rd_we_o}, 64'd0);
            step();
        end
        ld_valid_i = 1'b1;
        #1;
        chk("ld_resp_we", {63'd0, rd_we_o}, 64'd1);
        chk("ld_resp_sel", {62'd0, rdmux_sel_o}, 64'd2);
        step(); exp_instret++;
        ld_valid_i = 1'b0;
        #1;
        chk("ld_done_busy", {63'd0, busy_o}, 64'd0);
        chk("ld_done_ready", {63'd0, ready_o}, 64'd1);
        chk_instret("ld_instret");

        // load fault
        valid_i = 1'b1; wb_type_i = WB_LOAD; rd_addr_i = 5'd9; pc_i = 32'h300;
        step();
        valid_i = 1'b0; ld_valid_i = 1'b1; ld_err_i = 1'b1;
        #1;
        chk("fault_exc", {63'd0, ld_exc_o}, 64'd1);
        chk("fault_we", {63'd0, rd_we_o}, 64'd0);
        step();
        ld_valid_i = 1'b0; ld_err_i = 1'b0;
        #1;
        chk("fault_exc_gone", {63'd0, ld_exc_o}, 64'd0);
        chk("fault_busy", {63'd0, busy_o}, 64'd0);
        chk_instret("fault_instret");

        // rd=x0 ALU, then a load flushed while its response arrives
        present(WB_ALU, 5'd0, 32'h400, 32'hbeef);
        step();
        valid_i = 1'b1; wb_type_i = WB_LOAD; rd_addr_i = 5'd3; pc_i = 32'h404;
        #1;
        chk("x0_we", {63'd0, rd_we_o}, 64'd0);
        chk("x0_busy_rd", {59'd0, busy_rd_o}, 64'd0);
        step(); exp_instret++;
        valid_i = 1'b0; flush_i = 1'b1; ld_valid_i = 1'b1;
        #1;
        chk("flush_busy_rd", {59'd0, busy_rd_o}, 64'd3);
        chk("flush_we", {63'd0, rd_we_o}, 64'd0);
        chk("flush_exc", {63'd0, ld_exc_o}, 64'd0);
        step();
        flush_i = 1'b0; ld_valid_i = 1'b0;
        #1;
        chk("flush_idle", {63'd0, busy_o}, 64'd0);
        chk_instret("flush_instret");

        // flush beats a simultaneous accept
        valid_i = 1'b1; flush_i = 1'b1; wb_type_i = WB_ALU; rd_addr_i = 5'd4; alu_result_i = 32'h77;
        #1;
        chk("flush_acc_ready", {63'd0, ready_o}, 64'd1);
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("flush_acc_busy", {63'd0, busy_o}, 64'd0);

        // stray load response in IDLE is ignored
        ld_valid_i = 1'b1;
        #1;
        chk("stray_ld_we", {63'd0, rd_we_o}, 64'd0);
        step();
        ld_valid_i = 1'b0;

        // reset while waiting for a load
        valid_i = 1'b1; wb_type_i = WB_LOAD; rd_addr_i = 5'd6; pc_i = 32'h500;
        step();
        valid_i = 1'b0; reset_i = 1'b1; ld_valid_i = 1'b1;
        #1;
        chk("rst_ld_we", {63'd0, rd_we_o}, 64'd0);
        step();
        reset_i = 1'b0; ld_valid_i = 1'b0; exp_instret = 64'd0;
        #1;
        chk("rst_ld_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ld_ready", {63'd0, ready_o}, 64'd1);
        chk_instret("rst_ld_instret");

`ifdef RVGA_INSTRET_EN
        force dut.u_instret_counter.r_count = 64'hffff_ffff_ffff_ffff;
        #1;
        release dut.u_instret_counter.r_count;
        exp_instret = 64'hffff_ffff_ffff_ffff;
        chk_instret("wrap_preload");
        present(WB_ALU, 5'd8, 32'h600, 32'h99);
        step();
        valid_i = 1'b0;
        step(); exp_instret++;
        chk_instret("wrap_zero");
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
